// File: rtl/cordic_pkg.sv
// Shared constants and elaboration-time helpers for the CORDIC engine.
// Binary angles: full scale 2^angle_w represents 360 degrees.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam logic [15:0] INV_GAIN_Q15 = 16'h4DBA;

  function automatic logic [63:0] ang_90(input int unsigned angle_w);
    return 64'd1 << (angle_w - 2);
  endfunction

  function automatic logic [63:0] ang_45(input int unsigned angle_w);
    return 64'd1 << (angle_w - 3);
  endfunction

  // round(atan(2^-idx) * 2^32 / 360deg)
  function automatic logic [31:0] atan_q32(input int unsigned idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028C;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00A3;
      23:      return 32'h0000_0051;
      24:      return 32'h0000_0029;
      25:      return 32'h0000_0014;
      26:      return 32'h0000_000A;
      27:      return 32'h0000_0005;
      28:      return 32'h0000_0003;
      29:      return 32'h0000_0001;
      30:      return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Rescale the 32-bit table to the requested angle width with rounding.
  function automatic logic [63:0] atan_entry(input int unsigned angle_w, input int unsigned idx);
    logic [63:0]  base;
    int unsigned  sh;
    base = {32'd0, atan_q32(idx)};
    if (angle_w >= 32) return base << (angle_w - 32);
    sh = 32 - angle_w;
    return (base + (64'd1 << (sh - 1))) >> sh;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT), carrying the sample's sideband.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned XW      = 18,
  parameter int unsigned ANGLE_W = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SHIFT   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_mode,
  input  logic                      in_zero,
  input  logic signed [XW-1:0]      in_x,
  input  logic signed [XW-1:0]      in_y,
  input  logic signed [ANGLE_W-1:0] in_z,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  output logic                      out_mode,
  output logic                      out_zero,
  output logic signed [XW-1:0]      out_x,
  output logic signed [XW-1:0]      out_y,
  output logic signed [ANGLE_W-1:0] out_z,
  output logic [TAG_W-1:0]          out_tag
);

  localparam logic signed [ANGLE_W-1:0] ATAN = ANGLE_W'(atan_entry(ANGLE_W, SHIFT));

  logic signed [XW-1:0]      x_sh, y_sh, x_d, y_d;
  logic signed [ANGLE_W-1:0] z_d;
  logic                      d_pos;

  always_comb begin
    x_sh  = in_x >>> SHIFT;
    y_sh  = in_y >>> SHIFT;
    // Rotation drives z to 0; vectoring drives y to 0.
    d_pos = (in_mode == MODE_VEC) ? in_y[XW-1] : ~in_z[ANGLE_W-1];
    if (d_pos) begin
      x_d = in_x - y_sh;
      y_d = in_y + x_sh;
      z_d = in_z - ATAN;
    end else begin
      x_d = in_x + y_sh;
      y_d = in_y - x_sh;
      z_d = in_z + ATAN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_zero  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_zero  <= in_zero;
      out_x     <= x_d;
      out_y     <= y_d;
      out_z     <= z_d;
      out_tag   <= in_tag;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Pipelined CORDIC: quadrant pre-rotation, STAGES micro-rotations, optional 1/K gain stage,
// symmetric output saturation. Rotation or vectoring is chosen per sample.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGES    = 16,
  parameter int unsigned ANGLE_W   = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned GAIN_COMP = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_mode,
  input  logic signed [WIDTH-1:0]   in_x,
  input  logic signed [WIDTH-1:0]   in_y,
  input  logic [ANGLE_W-1:0]        in_angle,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  output logic                      out_mode,
  output logic signed [WIDTH-1:0]   out_x,
  output logic signed [WIDTH-1:0]   out_y,
  output logic [ANGLE_W-1:0]        out_angle,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned FW = (GAIN_COMP != 0) ? XW + 17 : XW;
  localparam logic [ANGLE_W-1:0] A90 = ANGLE_W'(ang_90(ANGLE_W));
  localparam logic signed [FW-1:0] SAT_MAX = FW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [FW-1:0] SAT_MIN = -SAT_MAX;

  // Pre-rotation
  logic signed [XW-1:0]      ix, iy, pre_x_d, pre_y_d, pre_x_q, pre_y_q;
  logic signed [ANGLE_W-1:0] pre_z_d, pre_z_q;
  logic                      pre_zero_d, pre_zero_q, pre_valid_q, pre_mode_q;
  logic [TAG_W-1:0]          pre_tag_q;

  assign ix = XW'(in_x);
  assign iy = XW'(in_y);

  always_comb begin
    pre_x_d    = ix;
    pre_y_d    = iy;
    pre_z_d    = in_angle;
    pre_zero_d = 1'b0;
    if (in_mode == MODE_ROT) begin
      unique case (in_angle[ANGLE_W-1 -: 2])
        2'b01: begin
          pre_x_d = -iy;
          pre_y_d = ix;
          pre_z_d = in_angle - A90;
        end
        2'b10: begin
          pre_x_d = iy;
          pre_y_d = -ix;
          pre_z_d = in_angle + A90;
        end
        default: ;
      endcase
    end else begin
      pre_z_d    = '0;
      pre_zero_d = (in_x == '0) && (in_y == '0);
      // Fold the left half-plane into the right so the stages can converge.
      if (ix < 0) begin
        if (iy >= 0) begin
          pre_x_d = iy;
          pre_y_d = -ix;
          pre_z_d = A90;
        end else begin
          pre_x_d = -iy;
          pre_y_d = ix;
          pre_z_d = -A90;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_valid_q <= 1'b0;
      pre_mode_q  <= 1'b0;
      pre_zero_q  <= 1'b0;
      pre_x_q     <= '0;
      pre_y_q     <= '0;
      pre_z_q     <= '0;
      pre_tag_q   <= '0;
    end else begin
      pre_valid_q <= in_valid;
      pre_mode_q  <= in_mode;
      pre_zero_q  <= pre_zero_d;
      pre_x_q     <= pre_x_d;
      pre_y_q     <= pre_y_d;
      pre_z_q     <= pre_z_d;
      pre_tag_q   <= in_tag;
    end
  end

  // Micro-rotation chain
  logic signed [XW-1:0]      sx [STAGES+1];
  logic signed [XW-1:0]      sy [STAGES+1];
  logic signed [ANGLE_W-1:0] sz [STAGES+1];
  logic                      sv [STAGES+1];
  logic                      sm [STAGES+1];
  logic                      sf [STAGES+1];
  logic [TAG_W-1:0]          st [STAGES+1];

  assign sx[0] = pre_x_q;
  assign sy[0] = pre_y_q;
  assign sz[0] = pre_z_q;
  assign sv[0] = pre_valid_q;
  assign sm[0] = pre_mode_q;
  assign sf[0] = pre_zero_q;
  assign st[0] = pre_tag_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .XW      (XW),
      .ANGLE_W (ANGLE_W),
      .TAG_W   (TAG_W),
      .SHIFT   (i)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (sv[i]),
      .in_mode   (sm[i]),
      .in_zero   (sf[i]),
      .in_x      (sx[i]),
      .in_y      (sy[i]),
      .in_z      (sz[i]),
      .in_tag    (st[i]),
      .out_valid (sv[i+1]),
      .out_mode  (sm[i+1]),
      .out_zero  (sf[i+1]),
      .out_x     (sx[i+1]),
      .out_y     (sy[i+1]),
      .out_z     (sz[i+1]),
      .out_tag   (st[i+1])
    );
  end

  // Optional gain compensation
  logic signed [FW-1:0]      fin_x, fin_y;
  logic signed [ANGLE_W-1:0] fin_z;
  logic                      fin_valid, fin_mode, fin_zero;
  logic [TAG_W-1:0]          fin_tag;

  if (GAIN_COMP != 0) begin : g_gain
    localparam logic signed [FW-1:0] K    = FW'($signed({1'b0, INV_GAIN_Q15}));
    localparam logic signed [FW-1:0] HALF = FW'(16384);

    logic signed [FW-1:0] gx_d, gy_d;

    // Full-width product keeps headroom; saturation happens at the output.
    always_comb begin
      gx_d = (FW'(sx[STAGES]) * K + HALF) >>> 15;
      gy_d = (FW'(sy[STAGES]) * K + HALF) >>> 15;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        fin_valid <= 1'b0;
        fin_mode  <= 1'b0;
        fin_zero  <= 1'b0;
        fin_x     <= '0;
        fin_y     <= '0;
        fin_z     <= '0;
        fin_tag   <= '0;
      end else begin
        fin_valid <= sv[STAGES];
        fin_mode  <= sm[STAGES];
        fin_zero  <= sf[STAGES];
        fin_x     <= gx_d;
        fin_y     <= gy_d;
        fin_z     <= sz[STAGES];
        fin_tag   <= st[STAGES];
      end
    end
  end else begin : g_nogain
    assign fin_valid = sv[STAGES];
    assign fin_mode  = sm[STAGES];
    assign fin_zero  = sf[STAGES];
    assign fin_x     = sx[STAGES];
    assign fin_y     = sy[STAGES];
    assign fin_z     = sz[STAGES];
    assign fin_tag   = st[STAGES];
  end

  // Output saturation
  logic signed [WIDTH-1:0] sat_x, sat_y;

  always_comb begin
    if (fin_x > SAT_MAX)      sat_x = SAT_MAX[WIDTH-1:0];
    else if (fin_x < SAT_MIN) sat_x = SAT_MIN[WIDTH-1:0];
    else                      sat_x = fin_x[WIDTH-1:0];
    if (fin_y > SAT_MAX)      sat_y = SAT_MAX[WIDTH-1:0];
    else if (fin_y < SAT_MIN) sat_y = SAT_MIN[WIDTH-1:0];
    else                      sat_y = fin_y[WIDTH-1:0];
  end

  always_comb begin
    out_valid = fin_valid;
    out_mode  = fin_mode;
    out_tag   = fin_tag;
    out_y     = sat_y;
    out_x     = fin_zero ? '0 : sat_x;
    out_angle = fin_zero ? '0 : fin_z;
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine; a second instance without gain compensation
// covers output saturation.
module tb_cordic_engine;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned STAGES  = 16;
  localparam int unsigned ANGLE_W = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int L     = 1 + STAGES + 1;
  localparam int L_RAW = 1 + STAGES;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_mode = 1'b0;
  logic signed [WIDTH-1:0]  in_x = '0;
  logic signed [WIDTH-1:0]  in_y = '0;
  logic [ANGLE_W-1:0]       in_angle = '0;
  logic [TAG_W-1:0]         in_tag = '0;

  logic                     out_valid, out_mode;
  logic signed [WIDTH-1:0]  out_x, out_y;
  logic [ANGLE_W-1:0]       out_angle;
  logic [TAG_W-1:0]         out_tag;

  logic                     raw_valid, raw_mode;
  logic signed [WIDTH-1:0]  raw_x, raw_y;
  logic [ANGLE_W-1:0]       raw_angle;
  logic [TAG_W-1:0]         raw_tag;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  cordic_engine #(
    .WIDTH(WIDTH), .STAGES(STAGES), .ANGLE_W(ANGLE_W), .TAG_W(TAG_W), .GAIN_COMP(1)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_tag(in_tag),
    .out_valid(out_valid), .out_mode(out_mode), .out_x(out_x), .out_y(out_y),
    .out_angle(out_angle), .out_tag(out_tag)
  );

  cordic_engine #(
    .WIDTH(WIDTH), .STAGES(STAGES), .ANGLE_W(ANGLE_W), .TAG_W(TAG_W), .GAIN_COMP(0)
  ) dut_raw (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_tag(in_tag),
    .out_valid(raw_valid), .out_mode(raw_mode), .out_x(raw_x), .out_y(raw_y),
    .out_angle(raw_angle), .out_tag(raw_tag)
  );

  // Drive one sample at the current negedge, then wait until its result is due on dut.
  task automatic send_one(input logic mode, input int x, input int y,
                          input logic [ANGLE_W-1:0] ang, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_x     = WIDTH'(x);
    in_y     = WIDTH'(y);
    in_angle = ang;
    in_tag   = tag;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (L - 1) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    tests_run++;
    if (out_x !== '0) begin tests_failed++; $display("FAIL reset_x got %0d want 0", out_x); end
    tests_run++;
    if (out_y !== '0) begin tests_failed++; $display("FAIL reset_y got %0d want 0", out_y); end
    tests_run++;
    if (out_angle !== '0) begin tests_failed++; $display("FAIL reset_angle got %h want 0", out_angle); end
    tests_run++;
    if (out_tag !== '0 || out_mode !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tag_mode got %h/%b want 0/0", out_tag, out_mode);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_rot45();
    int dx, dy;
    send_one(1'b0, 32000, 0, 32'h2000_0000, 4'hA);
    dx = int'(out_x) - 22627;
    dy = int'(out_y) - 22627;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rot45_latency valid got %0b want 1", out_valid); end
    tests_run++;
    if (dx > 4 || dx < -4) begin tests_failed++; $display("FAIL rot45_x got %0d want 22627+-4", out_x); end
    tests_run++;
    if (dy > 4 || dy < -4) begin tests_failed++; $display("FAIL rot45_y got %0d want 22627+-4", out_y); end
    tests_run++;
    if (out_tag !== 4'hA || out_mode !== 1'b0) begin
      tests_failed++; $display("FAIL rot45_tag_mode got %h/%b want a/0", out_tag, out_mode);
    end
  endtask

  task automatic test_rot_quadrants();
    logic [ANGLE_W-1:0] qa [3];
    int qx [3];
    int qy [3];
    int dx, dy;
    qa = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    qx = '{0, -32000, 0};
    qy = '{32000, 0, -32000};
    for (int k = 0; k < 3; k++) begin
      send_one(1'b0, 32000, 0, qa[k], TAG_W'(k + 1));
      dx = int'(out_x) - qx[k];
      dy = int'(out_y) - qy[k];
      tests_run++;
      if (out_valid !== 1'b1 || dx > 4 || dx < -4 || dy > 4 || dy < -4) begin
        tests_failed++;
        $display("FAIL rot_quad angle=%h got v=%0b x=%0d y=%0d want v=1 x=%0d y=%0d (+-4)",
                 qa[k], out_valid, out_x, out_y, qx[k], qy[k]);
      end
    end
  endtask

  task automatic test_vectoring();
    int dx;
    logic signed [ANGLE_W-1:0] da;
    send_one(1'b1, -20000, -20000, 32'h1234_5678, 4'h5);
    dx = int'(out_x) - 28284;
    da = out_angle - 32'hA000_0000;
    tests_run++;
    if (out_valid !== 1'b1 || dx > 4 || dx < -4) begin
      tests_failed++; $display("FAIL vec_mag got v=%0b x=%0d want v=1 x=28284+-4", out_valid, out_x);
    end
    tests_run++;
    if (da > 32'sd262144 || da < -32'sd262144) begin
      tests_failed++; $display("FAIL vec_phase got %h want a0000000+-40000", out_angle);
    end
    tests_run++;
    if (out_mode !== 1'b1 || out_tag !== 4'h5) begin
      tests_failed++; $display("FAIL vec_mode_tag got %b/%h want 1/5", out_mode, out_tag);
    end
    send_one(1'b1, 0, 0, 32'h0, 4'h6);
    tests_run++;
    if (out_valid !== 1'b1 || out_x !== '0 || out_angle !== '0) begin
      tests_failed++;
      $display("FAIL vec_zero got v=%0b x=%0d angle=%h want v=1 x=0 angle=0", out_valid, out_x, out_angle);
    end
  endtask

  task automatic test_back_to_back();
    logic bb_v [4];
    logic bb_m [4];
    int   bb_x [4];
    int   bb_y [4];
    logic [ANGLE_W-1:0] bb_a [4];
    int   bb_e [4];
    int   d;
    bb_v = '{1'b1, 1'b1, 1'b0, 1'b1};
    bb_m = '{1'b0, 1'b1, 1'b1, 1'b0};
    bb_x = '{32000, 3000, 0, 32000};
    bb_y = '{0, 4000, 0, 0};
    bb_a = '{32'h0, 32'h0, 32'h0, 32'h4000_0000};
    bb_e = '{32000, 5000, 0, 0};
    for (int k = 0; k < 4; k++) begin
      in_valid = bb_v[k];
      in_mode  = bb_m[k];
      in_x     = WIDTH'(bb_x[k]);
      in_y     = WIDTH'(bb_y[k]);
      in_angle = bb_a[k];
      in_tag   = TAG_W'(k + 1);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (L - 4) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      d = int'(out_x) - bb_e[k];
      tests_run++;
      if (out_valid !== bb_v[k]) begin
        tests_failed++; $display("FAIL b2b_valid slot=%0d got %0b want %0b", k, out_valid, bb_v[k]);
      end else if (bb_v[k] && (out_mode !== bb_m[k] || out_tag !== TAG_W'(k + 1)
                               || d > 4 || d < -4)) begin
        tests_failed++;
        $display("FAIL b2b_data slot=%0d got m=%b t=%h x=%0d want m=%b t=%h x=%0d+-4",
                 k, out_mode, out_tag, out_x, bb_m[k], TAG_W'(k + 1), bb_e[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_x     = 16'sd32767;
    in_y     = 16'sd32767;
    in_angle = '0;
    in_tag   = 4'h7;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (L_RAW - 1) @(negedge clock);
    tests_run++;
    if (raw_valid !== 1'b1 || raw_x !== 16'sd32767) begin
      tests_failed++; $display("FAIL sat_x got v=%0b x=%0d want v=1 x=32767", raw_valid, raw_x);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_midstream();
    int errs;
    int cnt;
    for (int k = 0; k < L + 2; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_x     = 16'sd1000;
      in_y     = '0;
      in_angle = '0;
      in_tag   = TAG_W'(k);
      @(negedge clock);
    end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_full got %0b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_x !== '0 || out_y !== '0 || out_angle !== '0
        || out_tag !== '0 || out_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear got v=%0b x=%0d y=%0d a=%h t=%h m=%b want all 0",
               out_valid, out_x, out_y, out_angle, out_tag, out_mode);
    end
    errs = 0;
    for (int k = 0; k < 2 * L; k++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL midrst_flush got %0d valid cycles want 0", errs); end
    in_valid = 1'b1;
    in_tag   = 4'h9;
    cnt = 0;
    @(negedge clock);
    in_valid = 1'b0;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 3 * L) begin
      @(negedge clock);
      cnt++;
    end
    tests_run++;
    if (cnt != L || out_tag !== 4'h9) begin
      tests_failed++; $display("FAIL midrst_latency got %0d cycles tag=%h want %0d tag=9", cnt, out_tag, L);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_rot45();
    test_rot_quadrants();
    test_vectoring();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
